serial_alu_wide: RTL and testbench

SERIAL_ALU_WIDE -- requirements
Module: serial_alu_wide

---
 rtl/serial_alu_wide_if.sv | 39 +++
 rtl/serial_alu_wide.sv | 215 +++++++++++++++++++++
 tb/tb_serial_alu_wide.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_wide_if.sv
// Request/response and debug signals of the serial wide ALU.
// The requester drives the master side. The ALU is the slave.
interface serial_alu_wide_if #(
    parameter int unsigned LOG2_NR   = 3,
    parameter int unsigned REG_BITS  = 8,
    parameter int unsigned NSHIFT    = 2,
    parameter int unsigned MAX_WORDS = 4
);
    logic                        start;
    logic [2:0]                  op;
    logic [$clog2(MAX_WORDS):0]  nwords;
    logic [LOG2_NR-1:0]          reg1;
    logic [LOG2_NR-1:0]          reg2;
    logic                        ext_arg2;
    logic                        writeback;
    logic                        flag_en;
    logic [NSHIFT-1:0]           data_in;
    logic                        busy;
    logic                        done;
    logic [NSHIFT-1:0]           data_out;
    logic                        flag_c;
    logic                        flag_v;
    logic                        flag_s;
    logic                        flag_z;
    logic [LOG2_NR-1:0]          dbg_sel;
    logic [REG_BITS-1:0]         dbg_data;

    modport master (
        output start, op, nwords, reg1, reg2, ext_arg2, writeback, flag_en,
               data_in, dbg_sel,
        input  busy, done, data_out, flag_c, flag_v, flag_s, flag_z, dbg_data
    );

    modport slave (
        input  start, op, nwords, reg1, reg2, ext_arg2, writeback, flag_en,
               data_in, dbg_sel,
        output busy, done, data_out, flag_c, flag_v, flag_s, flag_z, dbg_data
    );
endinterface

// File: rtl/serial_alu_wide.sv
// Bit-serial multi-word ALU over a small register file. Each cycle it handles one
// NSHIFT-bit chunk, LSB first, and chains the carry across chunks and word boundaries.
module serial_alu_wide #(
    parameter int unsigned LOG2_NR   = 3,
    parameter int unsigned REG_BITS  = 8,
    parameter int unsigned NSHIFT    = 2,
    parameter int unsigned MAX_WORDS = 4
) (
    input logic              clk,
    input logic              reset,
    serial_alu_wide_if.slave bus
);
    localparam int unsigned NR   = 1 << LOG2_NR;
    localparam int unsigned CPW  = REG_BITS / NSHIFT;
    localparam int unsigned CW   = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int unsigned NW_W = $clog2(MAX_WORDS) + 1;
    localparam int unsigned SW   = NSHIFT + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_ADC = 3'd2, OP_SBC = 3'd3,
        OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_MOV = 3'd7
    } op_t;

    typedef logic [CPW-1:0][NSHIFT-1:0] word_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [NW_W-1:0]    n_q, n_d;
    logic [LOG2_NR-1:0] r1_q, r1_d, r2_q, r2_d;
    logic               ext_q, ext_d, wb_q, wb_d, fen_q, fen_d;
    logic [CW-1:0]      cidx_q, cidx_d;
    logic [NW_W-1:0]    widx_q, widx_d;
    logic               carry_q, carry_d, zacc_q, zacc_d, done_q, done_d;
    logic               fc_q, fc_d, fv_q, fv_d, fs_q, fs_d, fz_q, fz_d;
    word_t              regs_q [NR];
    word_t              regs_d [NR];
    // Pre-op copy of the file so overlapping source/destination ranges read original values
    word_t              snap_q [NR];
    word_t              snap_d [NR];

    logic [LOG2_NR-1:0] a_idx, b_idx;
    logic [NSHIFT-1:0]  a_chk, b_chk, bb, res;
    logic [SW-1:0]      sum;
    logic               cout, ovf, arith, last, init_carry;
    logic [CW-1:0]      nxt_c;
    logic [NW_W-1:0]    nxt_w, n_eff;

    // Chunk datapath, evaluated every busy cycle from the current position
    always_comb begin
        a_idx = r1_q + LOG2_NR'(widx_q);
        b_idx = r2_q + LOG2_NR'(widx_q);
        a_chk = snap_q[a_idx][cidx_q];
        b_chk = ext_q ? bus.data_in : snap_q[b_idx][cidx_q];
        bb    = (op_q == OP_SUB || op_q == OP_SBC) ? ~b_chk : b_chk;
        sum   = {1'b0, a_chk} + {1'b0, bb} + SW'(carry_q);
        cout  = sum[NSHIFT];
        ovf   = (a_chk[NSHIFT-1] == bb[NSHIFT-1]) && (sum[NSHIFT-1] != a_chk[NSHIFT-1]);
        arith = (op_q inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC});
        case (op_q)
            OP_AND:  res = a_chk & b_chk;
            OP_OR:   res = a_chk | b_chk;
            OP_XOR:  res = a_chk ^ b_chk;
            OP_MOV:  res = b_chk;
            default: res = sum[NSHIFT-1:0];
        endcase
    end

    // Position bookkeeping and request decoding
    always_comb begin
        last = (cidx_q == CW'(CPW - 1)) && (widx_q == n_q - NW_W'(1));
        if (cidx_q == CW'(CPW - 1)) begin
            nxt_c = '0;
            nxt_w = widx_q + NW_W'(1);
        end else begin
            nxt_c = cidx_q + CW'(1);
            nxt_w = widx_q;
        end
        if (bus.nwords == '0) begin
            n_eff = NW_W'(1);
        end else if (bus.nwords > NW_W'(MAX_WORDS)) begin
            n_eff = NW_W'(MAX_WORDS);
        end else begin
            n_eff = bus.nwords;
        end
        case (op_t'(bus.op))
            OP_SUB:         init_carry = 1'b1;
            OP_ADC, OP_SBC: init_carry = fc_q;
            default:        init_carry = 1'b0;
        endcase
    end

    // Sequencer next-state and register/flag updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        n_d     = n_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        ext_d   = ext_q;
        wb_d    = wb_q;
        fen_d   = fen_q;
        cidx_d  = cidx_q;
        widx_d  = widx_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        done_d  = 1'b0;
        fc_d    = fc_q;
        fv_d    = fv_q;
        fs_d    = fs_q;
        fz_d    = fz_q;
        regs_d  = regs_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    op_d    = op_t'(bus.op);
                    n_d     = n_eff;
                    r1_d    = bus.reg1;
                    r2_d    = bus.reg2;
                    ext_d   = bus.ext_arg2;
                    wb_d    = bus.writeback;
                    fen_d   = bus.flag_en;
                    cidx_d  = '0;
                    widx_d  = '0;
                    carry_d = init_carry;
                    zacc_d  = 1'b1;
                    snap_d  = regs_q;
                    done_d  = (CPW == 1) && (n_eff == NW_W'(1));
                end
            end
            S_RUN: begin
                if (arith) begin
                    carry_d = cout;
                end
                zacc_d = zacc_q & (res == '0);
                if (wb_q) begin
                    regs_d[a_idx][cidx_q] = res;
                end
                if (last) begin
                    state_d = S_IDLE;
                    if (fen_q) begin
                        fs_d = res[NSHIFT-1];
                        fz_d = zacc_q & (res == '0);
                        if (arith) begin
                            fc_d = cout;
                            fv_d = ovf;
                        end
                    end
                end else begin
                    cidx_d = nxt_c;
                    widx_d = nxt_w;
                    done_d = (nxt_c == CW'(CPW - 1)) && (nxt_w == n_q - NW_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            n_q     <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            ext_q   <= 1'b0;
            wb_q    <= 1'b0;
            fen_q   <= 1'b0;
            cidx_q  <= '0;
            widx_q  <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            done_q  <= 1'b0;
            fc_q    <= 1'b0;
            fv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fz_q    <= 1'b0;
            regs_q  <= '{default: '0};
            snap_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            n_q     <= n_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            ext_q   <= ext_d;
            wb_q    <= wb_d;
            fen_q   <= fen_d;
            cidx_q  <= cidx_d;
            widx_q  <= widx_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            done_q  <= done_d;
            fc_q    <= fc_d;
            fv_q    <= fv_d;
            fs_q    <= fs_d;
            fz_q    <= fz_d;
            regs_q  <= regs_d;
            snap_q  <= snap_d;
        end
    end

    // The chunk result depends on this cycle's data_in, so data_out cannot be registered
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;
    assign bus.data_out = (state_q == S_RUN && !reset) ? res : '0;
    assign bus.flag_c   = fc_q;
    assign bus.flag_v   = fv_q;
    assign bus.flag_s   = fs_q;
    assign bus.flag_z   = fz_q;
    assign bus.dbg_data = regs_q[bus.dbg_sel];

endmodule

// File: tb/tb_serial_alu_wide.sv
// Directed-vector bench for serial_alu_wide (REG_BITS=8, NSHIFT=2, NR=8, MAX_WORDS=4).
module tb_serial_alu_wide;
    logic clk = 1'b0;
    logic reset;

    serial_alu_wide_if #(.LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .MAX_WORDS(4)) bus ();

    serial_alu_wide #(.LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .MAX_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          nb, da, nd;
    logic [31:0] dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z};
    endfunction

    task automatic chk_reg(input string tag, input int r, input logic [7:0] exp);
        @(negedge clk);
        bus.dbg_sel = 3'(r);
        #1;
        check(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    // Issue one op right away and follow it until busy drops (bounded).
    // poke_at/rst_at: busy cycle (1-based) on which to assert start/reset, 0 = never.
    task automatic do_op(input logic [2:0] op, input int nw, input int r1, input int r2,
                         input logic ext, input logic wb, input logic fen,
                         input logic [31:0] xdata, input int poke_at, input int rst_at);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.nwords    = 3'(nw);
        bus.reg1      = 3'(r1);
        bus.reg2      = 3'(r2);
        bus.ext_arg2  = ext;
        bus.writeback = wb;
        bus.flag_en   = fen;
        bus.data_in   = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nb = 0; da = -1; nd = 0; dout = '0;
        while (bus.busy === 1'b1 && nb < 64) begin
            bus.data_in = (nb < 16) ? xdata[2*nb +: 2] : 2'b00;
            if (nb + 1 == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 3'd6;
                bus.reg1  = 3'd7;
                bus.nwords = 3'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (nb + 1 == rst_at) reset = 1'b1;
            #1;
            nb++;
            if (nb <= 16) dout = dout | (32'(bus.data_out) << (2 * (nb - 1)));
            if (bus.done === 1'b1) begin
                nd++;
                da = nb;
            end
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic chk_run(input string tag, input int cycles);
        check({tag, "_cycles"}, 32'(nb), 32'(cycles));
        check({tag, "_done_at"}, 32'(da), 32'(cycles));
        check({tag, "_ndone"}, 32'(nd), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.nwords = '0; bus.reg1 = '0; bus.reg2 = '0;
        bus.ext_arg2 = 1'b0; bus.writeback = 1'b0; bus.flag_en = 1'b0;
        bus.data_in = '0; bus.dbg_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'd0);
        check("rst_flags", 32'(flags()), 32'b0000);
        for (int r = 0; r < 8; r++) chk_reg($sformatf("rst_reg%0d", r), r, 8'h00);

        // MOV 0x00FF into r0..r1, then ADD 0x0001 back-to-back
        do_op(3'd7, 2, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 0, 0);
        chk_run("mov2", 8);
        check("mov2_flags", 32'(flags()), 32'b0000);
        do_op(3'd0, 2, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 0, 0);
        chk_run("add2", 8);
        check("add2_flags", 32'(flags()), 32'b0000);
        chk_reg("add2_r0", 0, 8'h00);
        chk_reg("add2_r1", 1, 8'h01);

        // 0x80 - 0x01: signed overflow, no borrow
        do_op(3'd7, 1, 2, 0, 1'b1, 1'b1, 1'b0, 32'h80, 0, 0);
        chk_reg("mov_r2", 2, 8'h80);
        do_op(3'd1, 1, 2, 0, 1'b1, 1'b1, 1'b1, 32'h01, 0, 0);
        chk_run("sub", 4);
        check("sub_dout", dout, 32'h7F);
        check("sub_flags", 32'(flags()), 32'b1100);
        chk_reg("sub_r2", 2, 8'h7F);

        // CMP equal registers
        do_op(3'd7, 1, 3, 0, 1'b1, 1'b1, 1'b0, 32'h5A, 0, 0);
        do_op(3'd7, 1, 4, 0, 1'b1, 1'b1, 1'b0, 32'h5A, 0, 0);
        do_op(3'd1, 1, 3, 4, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
        chk_run("cmp", 4);
        check("cmp_dout", dout, 32'h00);
        check("cmp_flags", 32'(flags()), 32'b1001);
        chk_reg("cmp_r3", 3, 8'h5A);

        // ADC uses incoming C=1
        do_op(3'd7, 1, 5, 0, 1'b1, 1'b1, 1'b0, 32'hFF, 0, 0);
        check("mov_noflag", 32'(flags()), 32'b1001);
        do_op(3'd2, 1, 5, 0, 1'b1, 1'b1, 1'b1, 32'h00, 0, 0);
        check("adc_flags", 32'(flags()), 32'b1001);
        chk_reg("adc_r5", 5, 8'h00);

        // reg1 == reg2
        do_op(3'd7, 1, 6, 0, 1'b1, 1'b1, 1'b0, 32'h40, 0, 0);
        do_op(3'd0, 1, 6, 6, 1'b0, 1'b1, 1'b1, 32'h0, 0, 0);
        check("addself_flags", 32'(flags()), 32'b0110);
        chk_reg("addself_r6", 6, 8'h80);

        // Two-word SBC with C=0: 0x0100 - 0x0001 - 1
        do_op(3'd3, 2, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0001, 0, 0);
        check("sbc_flags", 32'(flags()), 32'b1000);
        chk_reg("sbc_r0", 0, 8'hFE);
        chk_reg("sbc_r1", 1, 8'h00);

        // Logic ops keep C/V
        do_op(3'd6, 1, 3, 6, 1'b0, 1'b1, 1'b1, 32'h0, 0, 0);
        check("xor_flags", 32'(flags()), 32'b1010);
        chk_reg("xor_r3", 3, 8'hDA);
        do_op(3'd5, 1, 3, 4, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
        check("or_dout", dout, 32'hDA);
        check("or_flags", 32'(flags()), 32'b1010);
        chk_reg("or_r3", 3, 8'hDA);
        do_op(3'd4, 1, 4, 0, 1'b1, 1'b1, 1'b1, 32'h00, 0, 0);
        check("and_flags", 32'(flags()), 32'b1001);
        chk_reg("and_r4", 4, 8'h00);

        // Overlapping ranges: r1<=r0, r2<=r1 using pre-op values
        do_op(3'd7, 2, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        chk_run("ovl", 8);
        chk_reg("ovl_r1", 1, 8'hFE);
        chk_reg("ovl_r2", 2, 8'h00);

        // Length clamps, with register wrap-around
        do_op(3'd7, 7, 6, 0, 1'b1, 1'b1, 1'b1, 32'h0102_0304, 0, 0);
        chk_run("clamp_hi", 16);
        check("clamp_hi_flags", 32'(flags()), 32'b1000);
        chk_reg("clamp_hi_r7", 7, 8'h03);
        chk_reg("clamp_hi_r0", 0, 8'h02);
        chk_reg("clamp_hi_r1", 1, 8'h01);
        do_op(3'd7, 0, 5, 0, 1'b1, 1'b1, 1'b1, 32'hAB, 0, 0);
        chk_run("clamp_lo", 4);
        check("clamp_lo_flags", 32'(flags()), 32'b1010);
        chk_reg("clamp_lo_r5", 5, 8'hAB);

        // Start while busy is ignored
        do_op(3'd7, 4, 0, 0, 1'b1, 1'b1, 1'b0, 32'h1122_3344, 2, 0);
        chk_run("poke", 16);
        chk_reg("poke_r0", 0, 8'h44);
        chk_reg("poke_r3", 3, 8'h11);

        // Reset on busy cycle 2 aborts the op
        do_op(3'd7, 4, 4, 0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 2);
        check("abort_cycles", 32'(nb), 32'd2);
        check("abort_ndone", 32'(nd), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_flags", 32'(flags()), 32'b0000);
        chk_reg("abort_r0", 0, 8'h00);
        chk_reg("abort_r4", 4, 8'h00);
        do_op(3'd7, 1, 0, 0, 1'b1, 1'b1, 1'b0, 32'h3C, 0, 0);
        chk_run("post_abort", 4);
        chk_reg("post_abort_r0", 0, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
